// File: rtl/chunk_sched_pkg.sv
// Shared types for the chunk fetch scheduler: FSM states and FIFO entry layout.
package chunk_sched_pkg;
  localparam int CHUNK_W = 128;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} sched_state_t;

  typedef struct packed {
    logic               last;
    logic [CHUNK_W-1:0] data;
  } chunk_entry_t;
endpackage

// File: rtl/chunk_sync_fifo.sv
// Small synchronous FIFO with combinational head read; DEPTH must be a power of two >= 2.
module chunk_sync_fifo
  import chunk_sched_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = chunk_entry_t,
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  input  logic          push,
  input  entry_t        wdata,
  input  logic          pop,
  output entry_t        rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  logic [AW-1:0] wr_ptr, rd_ptr;
  entry_t        mem [DEPTH];
  logic          do_push, do_pop;

  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO may still accept.
  assign do_push = push && (!full || do_pop);
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/chunk_fetch_scheduler.sv
// Frame readout sequencer: credit-limited BRAM reads into an AXI-Stream chunk FIFO.
// Optional CHUNK_SCHED_REPEAT_EN adds repeat_in to restart the same frame back-to-back.
module chunk_fetch_scheduler
  import chunk_sched_pkg::*;
#(
  parameter int ADDR_W           = 12,
  parameter int CHUNKS_PER_FRAME = 300,
  parameter int READ_LATENCY     = 2,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               start_in,
  input  logic [ADDR_W-1:0]  base_addr_in,
`ifdef CHUNK_SCHED_REPEAT_EN
  input  logic               repeat_in,
`endif
  output logic               busy_out,
  output logic               done_out,
  output logic               mem_en_out,
  output logic [ADDR_W-1:0]  mem_addr_out,
  input  logic [CHUNK_W-1:0] mem_rdata_in,
  output logic               chunk_tvalid,
  input  logic               chunk_tready,
  output logic [CHUNK_W-1:0] chunk_tdata,
  output logic               chunk_tlast
);
  localparam int IDX_W = ADDR_W + 1;
  localparam int CW    = $clog2(FIFO_DEPTH + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS_PER_FRAME - 1);

  sched_state_t            state;
  logic [ADDR_W-1:0]       base;
  logic [IDX_W-1:0]        issue_idx;
  logic [CW-1:0]           credits;
  logic [READ_LATENCY:1]   vld_pipe, last_pipe;
  logic                    issue, pop, again, drained;
  chunk_entry_t            push_entry, head;
  logic                    fifo_empty, unused_full;
  logic [CW-1:0]           fifo_count;

  assign issue        = (state == FETCH) && (credits != '0);
  assign pop          = chunk_tvalid && chunk_tready;
  assign mem_en_out   = issue;
  assign mem_addr_out = issue ? base + issue_idx[ADDR_W-1:0] : '0;
  // No in-flight reads and nothing buffered means the last chunk has been taken.
  assign drained      = (vld_pipe == '0) && (fifo_count == '0);

`ifdef CHUNK_SCHED_REPEAT_EN
  assign again = repeat_in;
`else
  assign again = 1'b0;
`endif

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) credits <= CW'(FIFO_DEPTH);
    else case ({issue, pop})
      2'b10:   credits <= credits - CW'(1);
      2'b01:   credits <= credits + CW'(1);
      default: ;
    endcase
  end

  // Tags each issued read so the returning data lands in the FIFO with its last flag.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
    end else begin
      vld_pipe[1]  <= issue;
      last_pipe[1] <= issue && (issue_idx == LAST_IDX);
      for (int k = 2; k <= READ_LATENCY; k++) begin
        vld_pipe[k]  <= vld_pipe[k-1];
        last_pipe[k] <= last_pipe[k-1];
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state     <= IDLE;
      base      <= '0;
      issue_idx <= '0;
      busy_out  <= 1'b0;
      done_out  <= 1'b0;
    end else begin
      done_out <= 1'b0;
      case (state)
        IDLE: if (start_in) begin
          base      <= base_addr_in;
          issue_idx <= '0;
          busy_out  <= 1'b1;
          state     <= FETCH;
        end
        FETCH: if (issue) begin
          issue_idx <= issue_idx + IDX_W'(1);
          if (issue_idx == LAST_IDX) state <= DRAIN;
        end
        DRAIN: if (drained) begin
          done_out  <= 1'b1;
          issue_idx <= '0;
          if (again) state <= FETCH;
          else begin
            busy_out <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign push_entry = '{last: last_pipe[READ_LATENCY], data: mem_rdata_in};

  chunk_sync_fifo #(.DEPTH(FIFO_DEPTH), .entry_t(chunk_entry_t)) u_fifo (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .push     (vld_pipe[READ_LATENCY]),
    .wdata    (push_entry),
    .pop      (pop),
    .rdata    (head),
    .full     (unused_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign chunk_tvalid = !fifo_empty;
  assign chunk_tdata  = head.data;
  assign chunk_tlast  = head.last;
endmodule
